trap_controller: RTL

Parametrised trap/exception controller for the program-flow unit. It generalises the single boot trap flag into a boot trap plus NUM_SRC maskable trap sources, with fixed priority and per-source vectors. Nesting is bounded by a return stack of saved PC and cause. It sits between the trap request sources and the fetch/PC logic: it supplies the redirect vector on entry and the saved PC on return-from-trap.

---
 rtl/trap_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// trap_controller: boot trap plus NUM_SRC maskable trap sources, with fixed
// priority (lowest cause wins) and per-source vectors. Nesting is bounded by
// a MAX_DEPTH-entry return stack that holds the saved PC and cause.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   first        first-instruction signal, rising edge raises the boot trap
//   trap_req     per-source request, level-sampled, sticky into pending
//   trap_en      per-source arbitration mask (does not block latching)
//   pc_in        PC saved on trap entry
//   rti          return-from-trap request
//   trap_mode    high while depth != 0
//   trap_take    one-cycle pulse on entry; trap_vec/trap_cause valid with it
//   trap_vec     entry vector, held until the next entry
//   trap_cause   cause of the top-of-stack entry (0 = boot, i+1 = source i)
//   ret_valid    one-cycle pulse on return; ret_pc valid with it
//   ret_pc       popped PC
//   depth        current nesting depth
//   overflow     sticky; a winning nested request was blocked by a full stack
module trap_controller #(
  parameter int unsigned       NUM_SRC   = 4,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] VEC_BASE  = 8'h80,
  parameter int unsigned       MAX_DEPTH = 4,
  localparam int unsigned      CW        = $clog2(NUM_SRC + 1),
  localparam int unsigned      DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              first,
  input  logic [NUM_SRC-1:0] trap_req,
  input  logic [NUM_SRC-1:0] trap_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              rti,
  output logic              trap_mode,
  output logic              trap_take,
  output logic [ADDR_W-1:0] trap_vec,
  output logic [CW-1:0]     trap_cause,
  output logic              ret_valid,
  output logic [ADDR_W-1:0] ret_pc,
  output logic [DW-1:0]     depth,
  output logic              overflow
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  typedef enum logic [1:0] {IDLE, TAKE, ACTIVE, RET} state_t;

  state_t              state, state_nxt;
  logic                first_q;
  logic [NUM_SRC:0]    pending, masked, set_vec, clr_vec;
  logic                win_valid;
  logic [CW-1:0]       win_cause;
  logic                do_take, do_ret, ovf_hit;
  logic [ADDR_W-1:0]   stk_pc    [MAX_DEPTH];
  logic [CW-1:0]       stk_cause [MAX_DEPTH];
  logic [ADDR_W-1:0]   top_pc;
  logic [CW-1:0]       below_cause;

  assign trap_mode = (depth != '0);
  assign set_vec   = {trap_req, first & ~first_q};

  // Lowest set bit of the masked pending vector wins; boot bit is never masked.
  always_comb begin
    masked    = pending & {trap_en, 1'b1};
    win_valid = 1'b0;
    win_cause = '0;
    for (int unsigned i = 0; i <= NUM_SRC; i++) begin
      if (masked[i] && !win_valid) begin
        win_valid = 1'b1;
        win_cause = CW'(i);
      end
    end
  end

  // Top entry (popped on return) and the entry beneath it (new top cause).
  always_comb begin
    top_pc      = '0;
    below_cause = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (i + 1 == 32'(depth)) top_pc = stk_pc[i];
      if (i + 2 == 32'(depth)) below_cause = stk_cause[i];
    end
  end

  // Entry and return actions fire on the edge that enters TAKE/RET, so the
  // pulses and depth change are registered at that edge; TAKE and RET are
  // then single hold cycles during which rti and arbitration are ignored.
  always_comb begin
    state_nxt = state;
    do_take   = 1'b0;
    do_ret    = 1'b0;
    ovf_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt = TAKE;
          do_take   = 1'b1;
        end
      end
      TAKE: state_nxt = ACTIVE;
      ACTIVE: begin
        if (rti) begin
          state_nxt = RET;
          do_ret    = 1'b1;
        end else if (win_valid && (win_cause < trap_cause)) begin
          if (depth < MAX_D) begin
            state_nxt = TAKE;
            do_take   = 1'b1;
          end else begin
            ovf_hit = 1'b1;
          end
        end
      end
      RET:     state_nxt = (depth != '0) ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (do_take) clr_vec = (NUM_SRC + 1)'(1) << win_cause;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q    <= 1'b0;
      pending    <= '0;
      depth      <= '0;
      overflow   <= 1'b0;
      trap_take  <= 1'b0;
      trap_vec   <= '0;
      trap_cause <= '0;
      ret_valid  <= 1'b0;
      ret_pc     <= '0;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
        stk_pc[i]    <= '0;
        stk_cause[i] <= '0;
      end
    end else begin
      first_q   <= first;
      trap_take <= do_take;
      ret_valid <= do_ret;
      // Set wins over clear for the same bit.
      pending   <= (pending & ~clr_vec) | set_vec;
      if (ovf_hit) overflow <= 1'b1;
      if (do_take) begin
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
          if (i == 32'(depth)) begin
            stk_pc[i]    <= pc_in;
            stk_cause[i] <= win_cause;
          end
        end
        depth      <= depth + DW'(1);
        trap_vec   <= VEC_BASE + (ADDR_W'(win_cause) << 2);
        trap_cause <= win_cause;
      end
      if (do_ret) begin
        depth      <= depth - DW'(1);
        ret_pc     <= top_pc;
        trap_cause <= below_cause;
      end
    end
  end

endmodule
